// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fix-up and the RISC-V divide special cases.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Decode of the incoming request, used only on the accept edge.
    logic            a_signed, b_signed, sign_a, sign_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                   (funct3 == F_DIV)  || (funct3 == F_REM);
        b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        sign_a   = a_signed & op_a[XLEN-1];
        sign_b   = b_signed & op_b[XLEN-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                   (op_a == MIN_NEG) && (op_b == '1);
        special  = div_zero || div_ovf;
        // funct3[1] selects the remainder flavour of a divide.
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration of the datapath; acc holds {partial/remainder, multiplier/quotient}.
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem, final_val, final_res;
    logic [2*XLEN-1:0] step, prod_signed;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];
        if (funct3_q[2]) begin
            step = {div_rem, acc_q[XLEN-2:0], div_ge};
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod_signed = neg_q ? -step : step;
        final_val   = funct3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        if (funct3_q[2]) begin
            final_res = neg_q ? -final_val : final_val;
        end else if (funct3_q == F_MUL) begin
            final_res = prod_signed[XLEN-1:0];
        end else begin
            final_res = prod_signed[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    funct3_d = funct3;
                    rd_d     = rd_in;
                    cnt_d    = '0;
                    opnd_d   = funct3[2] ? mag_b : mag_a;
                    acc_d    = {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                    // REM follows the dividend's sign; everything else the sign product.
                    neg_d    = (funct3 == F_REM) ? sign_a : (sign_a ^ sign_b);
                    if (special) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                    end else begin
                        state_d = S_CALC;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            rd_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a plain-arithmetic RV32M reference model,
// with directed cases for latency, ignored/back-to-back starts and mid-operation reset.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] up;
        longint      sp;
        int          sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op from a negedge; returns at the negedge where done is seen (chain=1)
    // or one cycle later (chain=0). poke_at>=0 re-asserts start during CALC.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit chain, input int poke_at);
        logic [31:0] er;
        bit          sp;
        int          edges, busy_cnt;
        er = ref_res(f3, a, b);
        sp = is_special(f3, a, b);
        exp_q.push_back(er);
        funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        busy_cnt = 0;
        check("rd_latched", {27'b0, rd_out}, {27'b0, rd});
        if (sp) check("busy_special", {31'b0, busy}, 32'd0);
        else    check("done_low_after_accept", {31'b0, done}, 32'd0);
        while (!done && edges < 200) begin
            if (busy) busy_cnt++;
            funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
            if (edges == poke_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            edges++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("done_edges", edges, sp ? 32'd0 : 32'(XLEN));
        if (!sp) check("busy_cycles", busy_cnt, 32'(XLEN));
        check("result", result, exp_q.pop_front());
        check("rd_out", {27'b0, rd_out}, {27'b0, rd});
        if (!chain) begin
            @(negedge clk);
            check("done_pulse", {31'b0, done}, 32'd0);
            check("result_hold", result, er);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN_NEG;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd", {27'b0, rd_out}, 32'd0);

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b0, -1);
        do_op(3'd1, MIN_NEG, MIN_NEG, 5'd4, 1'b0, -1);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0, -1);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b0, -1);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0, -1);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0, -1);
        do_op(3'd5, 32'd100, 32'd7, 5'd9, 1'b0, -1);
        do_op(3'd7, 32'd100, 32'd7, 5'd10, 1'b0, -1);
        do_op(3'd5, 32'h1234, 32'd0, 5'd11, 1'b0, -1);
        do_op(3'd6, 32'h1234, 32'd0, 5'd12, 1'b0, -1);
        do_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd0, 1'b0, -1);
        do_op(3'd0, 32'h0001_2345, 32'h0000_0678, 5'd13, 1'b0, 5);
        do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd14, 1'b1, -1);
        do_op(3'd4, 32'h8765_4321, 32'h0000_0013, 5'd15, 1'b1, -1);
        do_op(3'd7, 32'h0000_0042, 32'd0, 5'd16, 1'b1, -1);
        do_op(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd17, 1'b0, -1);

        // Reset sampled at the 10th edge after a DIV is accepted.
        funct3 = 3'd4; op_a = 32'h0BAD_F00D; op_b = 32'd3; rd_in = 5'd21; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_mid_div", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_rd", {27'b0, rd_out}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 32'd0);
        do_op(3'd4, 32'h0BAD_F00D, 32'd3, 5'd21, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
